// File: rtl/mq_pkg.sv
// Shared types for the MQ-coder CU output path: record layout and flush FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mq_pkg;

  // Default width of the shifted C/CT field carried from CU to BO.
  localparam int MQ_CW = 44;

  // One CU record as it travels to the byte-out stage; field order is the wire order.
  typedef struct packed {
    logic [1:0]       carry;
    logic [1:0]       renor;
    logic [MQ_CW-1:0] cshift;
    logic             addb;
    logic             rst_bo;
    logic             flush_bo;
  } mq_cu_rec_t;

  localparam int MQ_REC_W = $bits(mq_cu_rec_t);

  // RUN: accepting records. DRAIN: a flush record is queued and input is held off.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } mq_cu_fsm_t;

endpackage

// File: rtl/mq_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and full/empty flags.
// Latency: a push is visible on pop_data the cycle after it is written; no bypass.
// Backpressure: push is ignored when full, pop is ignored when empty.
module mq_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on accepted push only; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mq_cu_elastic_stage.sv
// Elastic CU->BO record buffer with flush ordering (no record may overtake a queued flush).
// Latency: 1 cycle from accepted push to out_valid; no same-cycle bypass.
// Backpressure: in_ready drops when full or while a flush record is still queued.
module mq_cu_elastic_stage
  import mq_pkg::*;
#(
  parameter int CW          = MQ_CW,
  parameter int DEPTH       = 4,
  parameter int FLUSH_BLOCK = 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_carry,
  input  logic [1:0]       in_renor,
  input  logic [CW-1:0]    in_cshift,
  input  logic             in_addb,
  input  logic             in_rst_cu,
  input  logic             in_flush_cu,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_carry,
  output logic [1:0]       out_renor,
  output logic [CW-1:0]    out_cshift,
  output logic             out_addb,
  output logic             out_rst_bo,
  output logic             out_flush_bo,
  output logic [CNT_W-1:0] count,
  output logic             draining
);

  // Same layout as mq_cu_rec_t, but sized by this instance's CW.
  typedef struct packed {
    logic [1:0]    carry;
    logic [1:0]    renor;
    logic [CW-1:0] cshift;
    logic          addb;
    logic          rst_bo;
    logic          flush_bo;
  } rec_t;

  rec_t       wr_rec;
  rec_t       rd_rec;
  rec_t       head;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  mq_cu_fsm_t state;
  mq_cu_fsm_t state_nxt;

  assign wr_rec = '{carry: in_carry, renor: in_renor, cshift: in_cshift,
                    addb: in_addb, rst_bo: in_rst_cu, flush_bo: in_flush_cu};

  assign draining  = (state == DRAIN);
  assign in_ready  = ~full & ~draining;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  mq_sync_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_rec),
    .pop       (pop),
    .pop_data  (rd_rec),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Flush FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Enter DRAIN when a flush is accepted; leave once BO has taken that flush record.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if ((FLUSH_BLOCK != 0) && push && in_flush_cu) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && rd_rec.flush_bo) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Zero all data fields when nothing valid is presented so BO never sees stale storage.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = rd_rec;
    end
  end

  assign out_carry    = head.carry;
  assign out_renor    = head.renor;
  assign out_cshift   = head.cshift;
  assign out_addb     = head.addb;
  assign out_rst_bo   = head.rst_bo;
  assign out_flush_bo = head.flush_bo;

endmodule

// File: tb/tb_mq_cu_elastic_stage.sv
// Bench for mq_cu_elastic_stage: directed scenarios plus a long random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_mq_cu_elastic_stage;
  import mq_pkg::*;

  localparam int CW    = MQ_CW;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREC  = 10000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_carry = '0;
  logic [1:0]       in_renor = '0;
  logic [CW-1:0]    in_cshift = '0;
  logic             in_addb = 1'b0;
  logic             in_rst_cu = 1'b0;
  logic             in_flush_cu = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_carry;
  logic [1:0]       out_renor;
  logic [CW-1:0]    out_cshift;
  logic             out_addb;
  logic             out_rst_bo;
  logic             out_flush_bo;
  logic [CNT_W-1:0] count;
  logic             draining;

  always #5 clk = ~clk;

  mq_cu_elastic_stage #(
    .CW          (CW),
    .DEPTH       (DEPTH),
    .FLUSH_BLOCK (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_carry     (in_carry),
    .in_renor     (in_renor),
    .in_cshift    (in_cshift),
    .in_addb      (in_addb),
    .in_rst_cu    (in_rst_cu),
    .in_flush_cu  (in_flush_cu),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_carry    (out_carry),
    .out_renor    (out_renor),
    .out_cshift   (out_cshift),
    .out_addb     (out_addb),
    .out_rst_bo   (out_rst_bo),
    .out_flush_bo (out_flush_bo),
    .count        (count),
    .draining     (draining)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  mq_cu_rec_t in_rec;
  mq_cu_rec_t out_rec;
  assign in_rec  = {in_carry, in_renor, in_cshift, in_addb, in_rst_cu, in_flush_cu};
  assign out_rec = {out_carry, out_renor, out_cshift, out_addb, out_rst_bo, out_flush_bo};

  // Reference model: a queue of accepted records plus one "flush outstanding" bit.
  mq_cu_rec_t model_q[$];
  bit         m_drain = 1'b0;
  bit         m_live  = 1'b0;
  mq_cu_rec_t exp_head;
  mq_cu_rec_t popped;
  bit         m_acc_in;
  bit         m_acc_out;

  always @(negedge clk) begin
    if (m_live) begin
      exp_head = (model_q.size() != 0) ? model_q[0] : '0;
      chk("count", count, model_q.size());
      chk("count_le_depth", count <= DEPTH, 1'b1);
      chk("out_valid", out_valid, model_q.size() != 0);
      chk("in_ready", in_ready, (model_q.size() < DEPTH) && !m_drain);
      chk("draining", draining, m_drain);
      chk("head_rec", out_rec, exp_head);
    end
    if (rst) begin
      model_q.delete();
      m_drain = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_acc_out = (model_q.size() != 0) && out_ready;
      m_acc_in  = in_valid && (model_q.size() < DEPTH) && !m_drain;
      if (m_acc_out) begin
        popped = model_q.pop_front();
        if (popped.flush_bo) m_drain = 1'b0;
      end
      if (m_acc_in) begin
        model_q.push_back(in_rec);
        if (in_rec.flush_bo) m_drain = 1'b1;
      end
    end
  end

  task automatic set_in(input mq_cu_rec_t r);
    in_carry    = r.carry;
    in_renor    = r.renor;
    in_cshift   = r.cshift;
    in_addb     = r.addb;
    in_rst_cu   = r.rst_bo;
    in_flush_cu = r.flush_bo;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a record and hold it until accepted (bounded).
  task automatic send(input mq_cu_rec_t r);
    int  n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    set_in(r);
    in_valid = 1'b1;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    chk("send_accepted", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (count != 0 && n < 2000) begin
      step();
      n++;
    end
    chk("drain_to_empty", count == 0, 1'b1);
  endtask

  function automatic mq_cu_rec_t rand_rec(input int flush_pct);
    mq_cu_rec_t r;
    logic [63:0] w;
    w          = {$urandom(), $urandom()};
    r.carry    = 2'($urandom_range(0, 3));
    r.renor    = 2'($urandom_range(0, 3));
    r.cshift   = w[CW-1:0];
    r.addb     = 1'($urandom_range(0, 1));
    r.rst_bo   = 1'($urandom_range(0, 1));
    r.flush_bo = ($urandom_range(0, 99) < flush_pct);
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  mq_cu_rec_t rec_a;
  mq_cu_rec_t r;
  int         sent;
  int         cyc;
  logic       acc;

  initial begin
    // Reset state
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_draining", draining, 0);
    chk("rst_out_zero", out_rec, 0);

    // Single record, one-cycle latency
    step();
    rec_a = '{carry: 2'b01, renor: 2'b10, cshift: 44'h0AB_CDEF_0123,
              addb: 1'b1, rst_bo: 1'b0, flush_bo: 1'b0};
    set_in(rec_a);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_out_valid", out_valid, 1);
    chk("single_rec", out_rec, rec_a);
    step();
    @(negedge clk);
    chk("single_count_after_pop", count, 0);
    chk("single_out_valid_after_pop", out_valid, 0);

    // Fill to full with BO stalled, then a held extra record
    step();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      r = rand_rec(0);
      send(r);
    end
    r = rand_rec(0);
    set_in(r);
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    repeat (3) step();
    @(negedge clk);
    chk("full_hold_count", count, DEPTH);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("full_pop_only_count", count, DEPTH - 1);
    chk("full_ready_after_pop", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("push_pop_count", count, DEPTH - 1);
    wait_empty();

    // Flush ordering with two records queued ahead of the flush
    step();
    out_ready = 1'b0;
    send(rand_rec(0));
    send(rand_rec(0));
    r = rand_rec(0);
    r.flush_bo = 1'b1;
    send(r);
    @(negedge clk);
    chk("flush_draining", draining, 1);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_count", count, 3);
    step();
    out_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("flush_still_draining", draining, 1);
    chk("flush_head_is_flush", out_flush_bo, 1);
    step();
    @(negedge clk);
    chk("flush_released_draining", draining, 0);
    chk("flush_released_in_ready", in_ready, 1);
    chk("flush_released_count", count, 0);

    // Reset in the middle of DRAIN
    step();
    out_ready = 1'b0;
    send(rand_rec(0));
    send(rand_rec(0));
    r = rand_rec(0);
    r.flush_bo = 1'b1;
    r.rst_bo   = 1'b1;
    send(r);
    @(negedge clk);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_draining", draining, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_zero", out_rec, 0);
    chk("mid_rst_draining", draining, 0);
    chk("mid_rst_in_ready", in_ready, 1);

    // Random traffic, checked every cycle by the model
    step();
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    while (sent < NREC && cyc < 60000) begin
      if (!in_valid || acc) begin
        set_in(rand_rec(3));
        in_valid = ($urandom_range(0, 9) < 8);
      end
      out_ready = ($urandom_range(0, 9) < 8);
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    chk("random_records_sent", sent, NREC);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty();
    step();
    @(negedge clk);
    chk("random_model_empty", model_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
